// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide/remainder behind a valid/ready handshake.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluSelection,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam logic [3:0]   OP_MUL = 4'b1100;
  localparam logic [3:0]   OP_DIV = 4'b1101;
  localparam logic [3:0]   OP_REM = 4'b1110;
  localparam logic [3:0]   OP_ILL = 4'b1111;
  localparam logic [SHW:0] ITERS  = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           r_state, w_nextState, w_launch;
  logic [SHW:0]     r_count;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_opA, r_opB, r_work;
  logic [WIDTH-1:0] r_aluOut;
  logic             r_zero, r_negative, r_carry, r_divByZero, r_illegal;

  logic             w_accept, w_isMul, w_isDivOp, w_bZero, w_multiCycle, w_lastIter;
  logic [WIDTH-1:0] w_result;
  logic             w_carry, w_divByZero, w_illegal;
  logic [WIDTH-1:0] w_mulWork, w_divWork, w_divQuo, w_iterResult;
  logic [WIDTH:0]   w_remShift, w_diff;
  logic             w_fits;

  assign in_ready     = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_accept     = in_valid & in_ready;
  assign w_isMul      = (aluSelection == OP_MUL);
  assign w_isDivOp    = (aluSelection == OP_DIV) || (aluSelection == OP_REM);
  assign w_bZero      = (dataB == '0);
  assign w_multiCycle = w_isMul || (w_isDivOp && !w_bZero);
  assign w_lastIter   = (r_count == (SHW+1)'(1));
  assign w_launch     = w_isMul ? MUL : ((w_isDivOp && !w_bZero) ? DIV : DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // A request accepted from DONE launches exactly as it would from IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_nextState = w_launch;
      MUL, DIV: if (w_lastIter) w_nextState = DONE;
      DONE: begin
        if (w_accept)       w_nextState = w_launch;
        else if (out_ready) w_nextState = IDLE;
      end
      default:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (w_accept)
      r_count <= w_multiCycle ? ITERS : '0;
    else if ((r_state == MUL || r_state == DIV) && r_count != '0)
      r_count <= r_count - (SHW+1)'(1);
  end

  always_comb begin
    w_result    = '0;
    w_carry     = 1'b0;
    w_divByZero = w_isDivOp && w_bZero;
    w_illegal   = (aluSelection == OP_ILL);
    case (aluSelection)
      4'b0000: w_result = dataA;
      4'b0001: {w_carry, w_result} = {1'b0, dataA} + {1'b0, dataB};
      4'b0010: {w_carry, w_result} = {1'b0, dataA} - {1'b0, dataB};
      4'b0011: {w_carry, w_result} = {1'b0, dataA} + (WIDTH+1)'(1);
      4'b0100: {w_carry, w_result} = {1'b0, dataA} - (WIDTH+1)'(1);
      4'b0101: w_result = dataA & dataB;
      4'b0110: w_result = dataA | dataB;
      4'b0111: w_result = dataA ^ dataB;
      4'b1000: w_result = ~dataA;
      4'b1001: w_result = dataA << shamt;
      4'b1010: w_result = dataA >> shamt;
      4'b1011: w_result = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
      OP_DIV:  w_result = '1;
      OP_REM:  w_result = dataA;
      default: w_result = '0;
    endcase
  end

  // r_work is the product accumulator in MUL and the partial remainder in DIV;
  // r_opA doubles as the shifted multiplicand or the dividend/quotient register.
  always_comb begin
    w_mulWork    = r_opB[0] ? (r_work + r_opA) : r_work;
    w_remShift   = {r_work, r_opA[WIDTH-1]};
    w_diff       = w_remShift - {1'b0, r_opB};
    w_fits       = ~w_diff[WIDTH];
    w_divWork    = w_fits ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    w_divQuo     = {r_opA[WIDTH-2:0], w_fits};
    w_iterResult = (r_op == OP_MUL) ? w_mulWork :
                   (r_op == OP_DIV) ? w_divQuo  : w_divWork;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op   <= '0;
      r_opA  <= '0;
      r_opB  <= '0;
      r_work <= '0;
    end else if (w_accept) begin
      r_op   <= aluSelection;
      r_opA  <= dataA;
      r_opB  <= dataB;
      r_work <= '0;
    end else if (r_state == MUL) begin
      r_work <= w_mulWork;
      r_opA  <= r_opA << 1;
      r_opB  <= r_opB >> 1;
    end else if (r_state == DIV) begin
      r_work <= w_divWork;
      r_opA  <= w_divQuo;
    end
  end

  // Result registers only change on a launch or on the final iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_aluOut    <= '0;
      r_zero      <= 1'b1;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_divByZero <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_multiCycle) begin
      r_aluOut    <= w_result;
      r_zero      <= (w_result == '0);
      r_negative  <= w_result[WIDTH-1];
      r_carry     <= w_carry;
      r_divByZero <= w_divByZero;
      r_illegal   <= w_illegal;
    end else if ((r_state == MUL || r_state == DIV) && w_lastIter) begin
      r_aluOut    <= w_iterResult;
      r_zero      <= (w_iterResult == '0);
      r_negative  <= w_iterResult[WIDTH-1];
      r_carry     <= 1'b0;
      r_divByZero <= 1'b0;
      r_illegal   <= 1'b0;
    end
  end

  assign out_valid   = (r_state == DONE);
  assign aluOut      = r_aluOut;
  assign zero        = r_zero;
  assign negative    = r_negative;
  assign carry       = r_carry;
  assign div_by_zero = r_divByZero;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors push expected results, a
// negedge monitor pops them on each output handshake and checks latency too.
module tb_seq_alu;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   aluSelection = '0;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic [4:0]   shamt = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] aluOut;
  logic         zero, negative, carry, div_by_zero, illegal;

  typedef struct {
    string        nm;
    logic [W-1:0] res;
    logic [4:0]   flags;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   seenCyc = 0;
  int   lastAccept = 0;
  bit   prevValid = 1'b0;
  bit   prevHs = 1'b1;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluSelection(aluSelection), .dataA(dataA), .dataB(dataB), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .aluOut(aluOut),
    .zero(zero), .negative(negative), .carry(carry),
    .div_by_zero(div_by_zero), .illegal(illegal)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency is measured from the cycle a result first appears.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prevValid = 1'b0;
      prevHs    = 1'b1;
    end else begin
      if (out_valid && (!prevValid || prevHs)) seenCyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected result: got %h, expected no output", aluOut);
        end else begin
          e = sb.pop_front();
          checkOutput({e.nm, " result"}, aluOut, e.res);
          checkOutput({e.nm, " flags"}, W'({zero, negative, carry, div_by_zero, illegal}), W'(e.flags));
          checkOutput({e.nm, " latency"}, W'(seenCyc - e.acc + 1), W'(e.lat));
        end
      end
      prevValid = out_valid;
      prevHs    = out_valid && out_ready;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [4:0] sh,
                               input logic [W-1:0] er, input logic [4:0] ef,
                               input int el, input bit track);
    int   waitCnt = 0;
    exp_t e;
    aluSelection = op;
    dataA = a;
    dataB = b;
    shamt = sh;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waitCnt < 100) begin
      @(posedge clock);
      #2;
      waitCnt++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s accept: got in_ready=0, expected 1 within 100 cycles", nm);
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      return;
    end
    @(posedge clock);
    #1;
    lastAccept = cyc;
    if (track) begin
      e.nm = nm; e.res = er; e.flags = ef; e.lat = el; e.acc = cyc;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    dataA = W'($urandom);
    dataB = W'($urandom);
    shamt = 5'($urandom);
    aluSelection = 4'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit busyOk;
    bit noStale;
    int startCyc;

    #1 reset = 1'b1;
    #2;
    checkOutput("reset out_valid", W'(out_valid), 0);
    checkOutput("reset aluOut", aluOut, 0);
    checkOutput("reset flags", W'({zero, negative, carry, div_by_zero, illegal}), W'(5'b10000));
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset in_ready", W'(in_ready), 1);

    applyStimulus("add wrap", 4'h1, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 5'b10100, 1, 1);
    waitDrain();
    applyStimulus("pass A", 4'h0, 32'h12345678, 32'h0, 0, 32'h12345678, 5'b00000, 1, 1);
    waitDrain();

    applyStimulus("mul", 4'hC, 32'h00010000, 32'h00010001, 0, 32'h00010000, 5'b00000, 33, 1);
    busyOk = 1'b1;
    aluSelection = 4'h1;
    dataA = 32'h1;
    dataB = 32'h1;
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (in_ready !== 1'b0) busyOk = 1'b0;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("mul in_ready low", W'(busyOk), 1);
    waitDrain();

    applyStimulus("mul max", 4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1, 5'b00000, 33, 1);
    waitDrain();
    applyStimulus("div", 4'hD, 32'd100, 32'd7, 0, 32'd14, 5'b00000, 33, 1);
    waitDrain();
    applyStimulus("rem", 4'hE, 32'd100, 32'd7, 0, 32'd2, 5'b00000, 33, 1);
    waitDrain();
    applyStimulus("div big", 4'hD, 32'hFFFFFFFF, 32'd10, 0, 32'h19999999, 5'b00000, 33, 1);
    waitDrain();
    applyStimulus("rem big", 4'hE, 32'hFFFFFFFF, 32'd10, 0, 32'd5, 5'b00000, 33, 1);
    waitDrain();
    applyStimulus("div by 0", 4'hD, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 5'b01010, 1, 1);
    waitDrain();
    applyStimulus("rem by 0", 4'hE, 32'd5, 32'd0, 0, 32'd5, 5'b00010, 1, 1);
    waitDrain();

    applyStimulus("illegal", 4'hF, 32'hDEADBEEF, 32'h1, 0, 32'h0, 5'b10001, 1, 1);
    waitDrain();
    applyStimulus("shl 31", 4'h9, 32'h1, 32'h0, 5'd31, 32'h80000000, 5'b01000, 1, 1);
    waitDrain();
    applyStimulus("shr 4", 4'hA, 32'h80000000, 32'h0, 5'd4, 32'h08000000, 5'b00000, 1, 1);
    waitDrain();
    applyStimulus("slt true", 4'hB, 32'd3, 32'd5, 0, 32'd1, 5'b00000, 1, 1);
    applyStimulus("slt false", 4'hB, 32'd5, 32'd3, 0, 32'd0, 5'b10000, 1, 1);
    applyStimulus("and", 4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 5'b01000, 1, 1);
    applyStimulus("or", 4'h6, 32'h0000000F, 32'h000000F0, 0, 32'h000000FF, 5'b00000, 1, 1);
    applyStimulus("xor", 4'h7, 32'hA5A5A5A5, 32'hFFFF0000, 0, 32'h5A5AA5A5, 5'b00000, 1, 1);
    applyStimulus("not", 4'h8, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 5'b01000, 1, 1);
    applyStimulus("inc", 4'h3, 32'd7, 32'h0, 0, 32'd8, 5'b00000, 1, 1);
    applyStimulus("dec 0", 4'h4, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 5'b01100, 1, 1);
    waitDrain();

    out_ready = 1'b0;
    applyStimulus("sub held", 4'h2, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 5'b01100, 1, 1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("hold aluOut", aluOut, 32'hFFFFFFFE);
      checkOutput("hold flags", W'({zero, negative, carry, div_by_zero, illegal}), W'(5'b01100));
      checkOutput("hold in_ready", W'(in_ready), 0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    startCyc = cyc;
    applyStimulus("b2b add", 4'h1, 32'd2, 32'd3, 0, 32'd5, 5'b00000, 1, 1);
    checkOutput("b2b accept cycle", W'(lastAccept - startCyc), 1);
    waitDrain();

    applyStimulus("div aborted", 4'hD, 32'd100, 32'd7, 0, 32'd14, 5'b00000, 33, 0);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    #1 reset = 1'b1;
    #1;
    checkOutput("abort out_valid", W'(out_valid), 0);
    checkOutput("abort aluOut", aluOut, 0);
    checkOutput("abort flags", W'({zero, negative, carry, div_by_zero, illegal}), W'(5'b10000));
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort in_ready", W'(in_ready), 1);
    noStale = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0) noStale = 1'b0;
      @(posedge clock);
      #1;
    end
    checkOutput("abort no stale result", W'(noStale), 1);

    applyStimulus("post reset add", 4'h1, 32'd40, 32'd2, 0, 32'd42, 5'b00000, 1, 1);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
